// File: rtl/seg_scan_if.sv
// Scanned 7-segment display bus: raw segment/select lines toward the
// decoder and the decoded digit registers plus pulses coming back.
interface seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [4*NUM_DIGITS-1:0] hex_out;
    logic [NUM_DIGITS-1:0]   dp_out;
    logic [NUM_DIGITS-1:0]   err_out;
    logic [NUM_DIGITS-1:0]   blank_out;
    logic                    upd;
    logic [IDX_W-1:0]        upd_idx;
    logic                    frame_vld;

    modport master (
        output seg, dig_sel,
        input  hex_out, dp_out, err_out, blank_out, upd, upd_idx, frame_vld
    );

    modport slave (
        input  seg, dig_sel,
        output hex_out, dp_out, err_out, blank_out, upd, upd_idx, frame_vld
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Multi-digit scanned 7-segment decoder. Synchronises the segment and
// digit-select lines, waits for STABLE_CYC identical samples of a one-hot
// select before committing a digit, decodes it to hex and tracks frames.
// Optional feature macro: SEG_BLANK_EN (all-segments-off decodes as blank).
module seg_scan_decoder #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYC     = 4,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    logic [7:0]            seg_sync [SYNC_STAGES];
    logic [NUM_DIGITS-1:0] sel_sync [SYNC_STAGES];
    logic [7:0]            s_seg;
    logic [NUM_DIGITS-1:0] s_sel;
    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic                  changed;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0] lat_sel;
    logic [7:0]            lat_seg;
    logic                  relatch;
    logic                  commit;

    logic [3:0]            dec_hex;
    logic                  dec_err;
    logic [NUM_DIGITS-1:0] seen_r, seen_nxt;
    logic                  frame_hit;

    logic [4*NUM_DIGITS-1:0] hex_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [NUM_DIGITS-1:0]   err_r;
    logic                    upd_r;
    logic [IDX_W-1:0]        idx_r;
    logic                    frame_r;
`ifdef SEG_BLANK_EN
    logic                    dec_blank;
    logic [NUM_DIGITS-1:0]   blank_r;
`endif

    // Input synchroniser chains for the asynchronous display lines
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                seg_sync[i] <= '0;
                sel_sync[i] <= '0;
            end
        end else begin
            seg_sync[0] <= bus.seg;
            sel_sync[0] <= bus.dig_sel;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                seg_sync[i] <= seg_sync[i-1];
                sel_sync[i] <= sel_sync[i-1];
            end
        end
    end

    // Select qualification: polarity fix, one-hot test and index encode
    always_comb begin
        s_seg     = seg_sync[SYNC_STAGES-1];
        s_sel     = DIG_ACTIVE_LOW ? ~sel_sync[SYNC_STAGES-1] : sel_sync[SYNC_STAGES-1];
        sel_valid = (s_sel != '0) && ((s_sel & (s_sel - NUM_DIGITS'(1))) == '0);
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (s_sel[i]) sel_idx = IDX_W'(i);
        end
        changed   = (s_sel != lat_sel) || (s_seg != lat_seg);
    end

    // State register with stability counter and latched sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_sel <= '0;
            lat_seg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (relatch) begin
                lat_sel <= s_sel;
                lat_seg <= s_seg;
            end
        end
    end

    // Next-state logic; commit fires whenever the upcoming count hits STABLE_CYC,
    // so a fresh sample commits immediately when STABLE_CYC is 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        relatch   = 1'b0;
        commit    = 1'b0;
        if (!sel_valid) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    relatch = 1'b1;
                    cnt_nxt = CNT_ONE;
                end
                TRACK: begin
                    if (changed) begin
                        relatch = 1'b1;
                        cnt_nxt = CNT_ONE;
                    end else if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        relatch = 1'b1;
                        cnt_nxt = CNT_ONE;
                    end
                end
                default: begin
                    relatch = 1'b1;
                    cnt_nxt = CNT_ONE;
                end
            endcase
            if (state == HOLD && !changed) begin
                state_nxt = HOLD;
            end else if (cnt_nxt == CNT_MAX) begin
                commit    = 1'b1;
                state_nxt = HOLD;
            end else begin
                state_nxt = TRACK;
            end
        end
    end

    // Output decode: segment table and frame completion
    always_comb begin
        dec_hex   = 4'h0;
        dec_err   = 1'b0;
`ifdef SEG_BLANK_EN
        dec_blank = 1'b0;
`endif
        case (s_seg[6:0])
            7'h3f: dec_hex = 4'h0;
            7'h06: dec_hex = 4'h1;
            7'h5b: dec_hex = 4'h2;
            7'h4f: dec_hex = 4'h3;
            7'h66: dec_hex = 4'h4;
            7'h6d: dec_hex = 4'h5;
            7'h7d: dec_hex = 4'h6;
            7'h07: dec_hex = 4'h7;
            7'h7f: dec_hex = 4'h8;
            7'h6f: dec_hex = 4'h9;
            7'h77: dec_hex = 4'hA;
            7'h7c: dec_hex = 4'hB;
            7'h39: dec_hex = 4'hC;
            7'h5e: dec_hex = 4'hD;
            7'h79: dec_hex = 4'hE;
            7'h71: dec_hex = 4'hF;
`ifdef SEG_BLANK_EN
            7'h00: dec_blank = 1'b1;
`endif
            default: dec_err = 1'b1;
        endcase
        seen_nxt  = seen_r | s_sel;
        frame_hit = commit && (seen_nxt == '1);
    end

    // Commit registers: per-digit results, pulses and seen-mask
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_r   <= '0;
            dp_r    <= '0;
            err_r   <= '0;
            upd_r   <= 1'b0;
            idx_r   <= '0;
            frame_r <= 1'b0;
            seen_r  <= '0;
`ifdef SEG_BLANK_EN
            blank_r <= '0;
`endif
        end else begin
            upd_r   <= commit;
            frame_r <= frame_hit;
            if (commit) begin
                hex_r[4*sel_idx +: 4] <= dec_hex;
                dp_r[sel_idx]         <= s_seg[7];
                err_r[sel_idx]        <= dec_err;
                idx_r                 <= sel_idx;
                seen_r                <= frame_hit ? '0 : seen_nxt;
`ifdef SEG_BLANK_EN
                blank_r[sel_idx]      <= dec_blank;
`endif
            end
        end
    end

    assign bus.hex_out   = hex_r;
    assign bus.dp_out    = dp_r;
    assign bus.err_out   = err_r;
    assign bus.upd       = upd_r;
    assign bus.upd_idx   = idx_r;
    assign bus.frame_vld = frame_r;
`ifdef SEG_BLANK_EN
    assign bus.blank_out = blank_r;
`else
    assign bus.blank_out = '0;
`endif
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus queues expected commits,
// a negedge monitor pops and compares on every upd pulse.
module tb_seg_scan_decoder;
`ifdef SEG_BLANK_EN
    localparam bit BLK = 1'b1;
`else
    localparam bit BLK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_decoder #(
        .NUM_DIGITS(4),
        .STABLE_CYC(4),
        .SYNC_STAGES(2),
        .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int unsigned idx;
        logic [3:0]  hex;
        logic        dp;
        logic        err;
        logic        blank;
        logic        frame;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned upd_cnt = 0;
    int unsigned frame_cnt = 0;
    int unsigned last_upd_cyc = 0;
    int unsigned t0, base_upd, base_frame;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input int unsigned idx, input logic [3:0] hex, input logic dp,
                              input logic err, input logic blank, input logic frame);
        exp_t e;
        e.idx = idx; e.hex = hex; e.dp = dp; e.err = err; e.blank = blank; e.frame = frame;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] sel, input logic [7:0] sg, input int unsigned n);
        bus.dig_sel = sel;
        bus.seg     = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle counter for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each commit pulse against the oldest expected entry
    always @(negedge clk) begin
        if (bus.upd) begin
            upd_cnt++;
            last_upd_cyc = cyc;
            if (bus.frame_vld) frame_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_upd: got upd on digit %0d, expected no commit", bus.upd_idx);
            end else begin
                mon_e = sb.pop_front();
                check("upd_idx",   32'(bus.upd_idx),            mon_e.idx);
                check("hex_digit", 32'(bus.hex_out[4*mon_e.idx +: 4]), 32'(mon_e.hex));
                check("dp_digit",  32'(bus.dp_out[mon_e.idx]),    32'(mon_e.dp));
                check("err_digit", 32'(bus.err_out[mon_e.idx]),   32'(mon_e.err));
                check("blank_digit", 32'(bus.blank_out[mon_e.idx]), 32'(mon_e.blank));
                check("frame_vld", 32'(bus.frame_vld),          32'(mon_e.frame));
            end
        end else if (bus.frame_vld) begin
            frame_cnt++;
            n_cmp++;
            n_bad++;
            $display("FAIL lone_frame_vld: got frame_vld=1 without upd, expected 0");
        end
    end

    initial begin
        rst         = 1'b1;
        bus.seg     = 8'h00;
        bus.dig_sel = 4'b0000;
        @(posedge clk);
        #1;

        // Reset held with inputs toggling
        for (int i = 0; i < 3; i++) begin
            bus.dig_sel = 4'b0001 << i;
            bus.seg     = 8'h5b ^ 8'(i);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.dig_sel = 4'b0000;
        check("rst_hex",   32'(bus.hex_out),   0);
        check("rst_dp",    32'(bus.dp_out),    0);
        check("rst_err",   32'(bus.err_out),   0);
        check("rst_blank", 32'(bus.blank_out), 0);
        check("rst_upd",   32'(bus.upd),       0);
        check("rst_frame", 32'(bus.frame_vld), 0);
        drive(4'b0000, 8'h00, 4);

        // Single commit and latency
        expect_upd(0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        base_upd = upd_cnt;
        drive(4'b0001, 8'h5b, 12);
        check("latency",      last_upd_cyc - t0, 6);
        check("single_count", upd_cnt - base_upd, 1);
        drive(4'b0000, 8'h00, 4);

        // Ghost filter: short-lived 1 must not commit
        expect_upd(2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        base_upd = upd_cnt;
        drive(4'b0100, 8'h06, 3);
        drive(4'b0100, 8'h4f, 10);
        check("ghost_count", upd_cnt - base_upd, 1);
        check("ghost_hex2",  32'(bus.hex_out[11:8]), 3);
        check("hold_hex0",   32'(bus.hex_out[3:0]),  2);
        drive(4'b0000, 8'h00, 4);

        // Clear seen-mask before the frame test
        rst = 1'b1;
        drive(4'b0000, 8'h00, 2);
        rst = 1'b0;
        check("rst2_hex", 32'(bus.hex_out), 0);
        drive(4'b0000, 8'h00, 2);

        // Full frame scan
        expect_upd(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_upd(1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_upd(2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_upd(3, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1);
        base_upd   = upd_cnt;
        base_frame = frame_cnt;
        drive(4'b0001, 8'h3f, 8);
        drive(4'b0010, 8'h06, 8);
        drive(4'b0100, 8'h5b, 8);
        drive(4'b1000, 8'hcf, 8);
        drive(4'b0000, 8'h00, 4);
        check("frame_hex",    32'(bus.hex_out), 32'h3210);
        check("frame_dp",     32'(bus.dp_out),  32'b1000);
        check("frame_upds",   upd_cnt - base_upd, 4);
        check("frame_pulses", frame_cnt - base_frame, 1);

        // Re-commit digit 0 alone: no frame
        expect_upd(0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        base_frame = frame_cnt;
        drive(4'b0001, 8'h3f, 10);
        drive(4'b0000, 8'h00, 4);
        check("no_frame", frame_cnt - base_frame, 0);

        // Illegal pattern
        expect_upd(1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'b0010, 8'h7e, 10);
        check("illegal_err1", 32'(bus.err_out[1]),   1);
        check("illegal_hex1", 32'(bus.hex_out[7:4]), 0);
        drive(4'b0000, 8'h00, 4);

        // Multi-hot select never commits
        base_upd = upd_cnt;
        drive(4'b0011, 8'h06, 20);
        drive(4'b0000, 8'h00, 4);
        check("multihot_count", upd_cnt - base_upd, 0);

        // Reset at cnt=3 on digit 3 abandons the count
        base_upd = upd_cnt;
        drive(4'b1000, 8'h06, 5);
        rst = 1'b1;
        drive(4'b0000, 8'h00, 2);
        rst = 1'b0;
        drive(4'b0000, 8'h00, 10);
        check("midrst_count", upd_cnt - base_upd, 0);
        check("midrst_hex",   32'(bus.hex_out), 0);
        check("midrst_err",   32'(bus.err_out), 0);

        // All-off pattern: blank when enabled, illegal otherwise
        expect_upd(0, 4'h0, 1'b0, !BLK, BLK, 1'b0);
        drive(4'b0001, 8'h00, 10);
        check("blank_vec", 32'(bus.blank_out), BLK ? 32'b0001 : 32'b0000);
        check("blank_err", 32'(bus.err_out[0]), BLK ? 0 : 1);
        drive(4'b0000, 8'h00, 4);

        check("pending_commits", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Parametrised multi-digit successor to the single-digit segment-to-hex decoder.
- Watches a time-multiplexed (scanned) 7-segment display bus: shared segment lines plus per-digit select lines.
- Filters scan ghosting with a stability counter, decodes each digit to a 4-bit hex value and holds all digits in registers.
- Pulses on each digit update and on each complete frame; feeds display-scraping and self-test logic.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..16)
STABLE_CYC, 4, consecutive identical samples required before a digit commits (>=1)
SYNC_STAGES, 2, synchroniser flops on seg/dig_sel inputs (>=1)
DIG_ACTIVE_LOW, 0, 1 = dig_sel lines active-low (inverted after sync)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
seg  in  8  bit7 = dp, bits6:0 = g..a, active-high, asynchronous to clk
dig_sel  in  NUM_DIGITS  digit select, one-hot when valid, asynchronous
hex_out  out  4*NUM_DIGITS  decoded value, digit i at [4i+3:4i]
dp_out  out  NUM_DIGITS  captured dp per digit
err_out  out  NUM_DIGITS  1 = last committed pattern was not a legal code
blank_out  out  NUM_DIGITS  blank flag (feature-dependent)
upd  out  1  one-cycle pulse, any digit committed
upd_idx  out  clog2(NUM_DIGITS) (min 1)  index of committed digit, valid with upd
frame_vld  out  1  one-cycle pulse, every digit committed since last pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset: all outputs 0, counter 0, seen-mask 0, FSM in IDLE. Reset asserted mid-count abandons the count, with no upd.
- seg and dig_sel pass through SYNC_STAGES flops. All decisions below act on the synchronised values (s_seg, s_sel).
- Select is valid only when s_sel is exactly one-hot. Zero or multi-hot select is invalid.
- FSM states:
  - IDLE: invalid select. Go to TRACK when select becomes valid, loading cnt=1 and latching (sel, seg).
  - TRACK: if select becomes invalid, go to IDLE. If sel or seg differs from the latched values, relatch and set cnt=1. Otherwise increment cnt. When cnt reaches STABLE_CYC, commit and go to HOLD.
  - HOLD: committed; no further commits while sel and seg stay unchanged. Any change goes to TRACK (cnt=1) or IDLE (invalid select).
- STABLE_CYC=1 commits on the first valid sample.
- Commit (registered, visible the cycle after the deciding edge):
  - hex_out digit written from seg[6:0] using the standard table: 3f->0, 06->1, 5b->2, 4f->3, 66->4, 6d->5, 7d->6, 07->7, 7f->8, 6f->9, 77->A, 7c->B, 39->C, 5e->D, 79->E, 71->F.
  - Any other pattern: hex=0, err=1. Legal pattern: err=0.
  - dp_out[i]=seg[7]; upd=1; upd_idx=i; seen-mask bit i set.
- Latency: a steady input reaches hex_out/upd SYNC_STAGES+STABLE_CYC cycles after it is applied at the pins.
- Frame: when a commit makes the seen-mask all ones, frame_vld pulses in the same cycle as that upd and the mask clears. Re-committing the same digit before the frame completes does not pulse frame_vld.
- Uncommitted digits hold their last values indefinitely.
- cnt saturates and never wraps. Its width is clog2(STABLE_CYC+1).

Optional Feature:
- Macro SEG_BLANK_EN.
- Defined: pattern 7'h00 is legal "blank". Commit hex=0, err=0, blank_out[i]=1. Any other commit clears blank_out[i].
- Undefined: 7'h00 is an illegal code (hex=0, err=1), and blank_out is tied to 0.

Test Plan:
All scenarios use NUM_DIGITS=4, STABLE_CYC=4, SYNC_STAGES=2, DIG_ACTIVE_LOW=0.
- Reset: hold rst 3 cycles with inputs toggling -> all outputs 0, no upd or frame_vld pulse.
- Single commit: dig_sel=4'b0001, seg=8'h5b held 12 cycles -> exactly one upd, 6 cycles after apply. upd_idx=0, hex_out[3:0]=4'h2, dp_out=0, err_out=0.
- Ghost filter: digit 2 gets seg=8'h06 for 3 cycles, then 8'h4f held -> no commit of 1. hex_out[11:8]=4'h3 with one upd.
- Full frame: scan digits 0..3 with 8'h3f, 8'h06, 8'h5b, 8'hcf, 8 cycles each -> hex_out=16'h3210, dp_out=4'b1000, 4 upd pulses, frame_vld once with the digit-3 upd. Repeating digit 0 alone gives no frame_vld.
- Illegal, invalid select and reset: seg=8'h7e on digit 1 -> hex_out[7:4]=0, err_out[1]=1. dig_sel=4'b0011 for 20 cycles -> no upd. rst at cnt=3 on digit 3 -> no commit.
- SEG_BLANK_EN: seg=8'h00 on digit 0 -> defined: blank_out[0]=1, err_out[0]=0. Undefined: err_out[0]=1, blank_out=0.
